mips_cpu_state_sequencer: RTL and testbench
===========================================

Name: mips_cpu_state_sequencer

Overview:
Multicycle state sequencer for the MIPS CPU. It owns the 3-bit state register that drives the combinational control decoder. It steps each instruction through FETCH/DECODE/EXECUTE/MEMORY_ACCESS/WRITE_BACK according to its class, and holds state while the Avalon memory or the multi-cycle mult/div unit is busy. It also detects the halt condition (fetch from address 0), runs a stall watchdog, and counts retired instructions.

Parameters:
STALL_LIMIT, 1024, consecutive stalled cycles tolerated before forced halt with error (must be >= 1)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
opcode  in  6  instruction[31:26] from instruction register (valid from DECODE onward)
func_code  in  6  instruction[5:0] from instruction register
pc  in  32  current program counter value
mem_read  in  1  MemRead from control decoder
mem_write  in  1  MemWrite from control decoder
waitrequest  in  1  Avalon waitrequest from memory
alu_busy  in  1  mult/div unit still computing
state  out  3  current state, encoding below
active  out  1  high while CPU running; low once HALTED
mem_enable  out  1  top level ANDs this with read/write strobes
stall  out  1  current cycle is a hold cycle
stall_error  out  1  sticky; watchdog expired
retired  out  CNT_W  instructions completed since reset

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, port reset.
- State encoding, fixed and shared with the decoder:
  - FETCH=000, DECODE=001, EXECUTE=010, MEMORY_ACCESS=011, WRITE_BACK=100, HALTED=101.
  - 110 and 111 are illegal and go to HALTED on the next edge.
- Reset values: state=FETCH, active=1, stall_error=0, retired=0, stall counter=0.
  - Reset asserted mid-instruction aborts it immediately; no count increment.
- Combinational outputs:
  - mem_enable = !(state==HALTED) && !(state==FETCH && pc==0).
  - stall = mem_access_stall || exec_stall, where:
    - mem_access_stall = (state==FETCH || state==MEMORY_ACCESS) && (mem_read||mem_write) && waitrequest && mem_enable.
    - exec_stall = state==EXECUTE && alu_busy.
  - active = (state != HALTED).
- Transitions (evaluated each edge; stall=1 holds state):
  - FETCH: pc==0 goes to HALTED (no memory access issued); otherwise goes to DECODE.
  - DECODE: always goes to EXECUTE.
  - EXECUTE goes to FETCH for:
    - opcode 0 with func JR(001000), MTHI(010001), MTLO(010011), MULT(011000), MULTU(011001), DIV(011010), DIVU(011011);
    - any opcode/func not listed below (treated as NOP).
  - EXECUTE goes to MEMORY_ACCESS for:
    - opcode 0 with ADDU, SUBU, AND, OR, XOR, SLT, SLTU, SLL, SLLV, SRL, SRLV, SRA, SRAV, JALR;
    - opcode ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LW, SW.
  - MEMORY_ACCESS: LW(100011) goes to WRITE_BACK; all others go to FETCH.
  - WRITE_BACK: always goes to FETCH.
  - HALTED: absorbing; only reset leaves it.
- retired: +1 on every edge that leaves EXECUTE, MEMORY_ACCESS or WRITE_BACK for FETCH. Wraps modulo 2^CNT_W; no saturation.
- Watchdog:
  - Counter +1 on each cycle with stall=1; cleared on any cycle with stall=0.
  - When the counter reaches STALL_LIMIT with stall still 1, the next edge sets state=HALTED and stall_error=1 (sticky until reset). That instruction is not retired.
- Stall and halt on the same cycle: in FETCH with pc==0, mem_enable=0 so stall=0, and halt wins.
- An alu_busy assertion outside EXECUTE is ignored; a waitrequest assertion in DECODE/EXECUTE/WRITE_BACK is ignored.

Test Plan:
- Reset with pc=0xBFC00000 and an ADDIU stream, waitrequest=0 -> state sequence 000,001,010,011,000; retired=1 after 4 edges.
- LW with waitrequest high for 3 cycles in MEMORY_ACCESS -> state holds 011 for 3 cycles with stall=1, then 100, then 000; retired +1.
- DIV with alu_busy high 5 cycles -> EXECUTE held 5 cycles, then FETCH; retired +1; JR -> EXECUTE straight to FETCH.
- JR to 0: pc=0 while in FETCH -> mem_enable=0 same cycle, next edge state=101, active=0; stays HALTED for 100 cycles with retired frozen.
- STALL_LIMIT=4, waitrequest stuck at 1 in FETCH -> state=101 and stall_error=1 after the 5th edge; retired unchanged.
- Reset asserted asynchronously mid-MEMORY_ACCESS (no clk edge) -> state=000, retired=0, stall_error=0 immediately; retired preset near 0xFFFFFFFF wraps to 0.

Source files
------------

// File: rtl/mips_cpu_state_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mips_cpu_state_sequencer
//  Description : Multicycle state sequencer for the MIPS CPU. Owns the 3-bit
//                state register, holds on memory/ALU stalls, detects halt
//                (fetch from address 0), runs a stall watchdog and counts
//                retired instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_cpu_state_sequencer #(
  parameter int STALL_LIMIT = 1024,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       func_code,
  input  logic [31:0]      pc,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             waitrequest,
  input  logic             alu_busy,
  output logic [2:0]       state,
  output logic             active,
  output logic             mem_enable,
  output logic             stall,
  output logic             stall_error,
  output logic [CNT_W-1:0] retired
);

  // Encoding is shared with the control decoder and must not change.
  typedef enum logic [2:0] {
    FETCH         = 3'b000,
    DECODE        = 3'b001,
    EXECUTE       = 3'b010,
    MEMORY_ACCESS = 3'b011,
    WRITE_BACK    = 3'b100,
    HALTED        = 3'b101
  } state_t;

  localparam logic [5:0] OP_LW = 6'b100011;

  // Watchdog counter only ever needs to reach STALL_LIMIT.
  localparam int             WD_W     = $clog2(STALL_LIMIT + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(STALL_LIMIT);

  state_t          state_q;
  state_t          next_state;
  logic [WD_W-1:0] wd_cnt;
  logic            mem_access_stall;
  logic            exec_stall;
  logic            wd_trip;
  logic            exec_to_mem;
  logic            retire;

  assign state      = state_q;
  assign active     = (state_q != HALTED);
  assign mem_enable = (state_q != HALTED) && !(state_q == FETCH && pc == 32'd0);

  assign mem_access_stall = (state_q == FETCH || state_q == MEMORY_ACCESS) &&
                            (mem_read || mem_write) && waitrequest && mem_enable;
  assign exec_stall       = (state_q == EXECUTE) && alu_busy;
  assign stall            = mem_access_stall || exec_stall;

  // Watchdog fires on a stalled cycle once the limit has already been counted.
  assign wd_trip = stall && (wd_cnt == WD_LIMIT);

  // Classify the instruction: results that need the MEMORY_ACCESS stage vs. done in EXECUTE.
  always_comb begin
    exec_to_mem = 1'b0;
    if (opcode == 6'b000000) begin
      case (func_code)
        6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b100110,
        6'b101010, 6'b101011, 6'b000000, 6'b000100, 6'b000010,
        6'b000110, 6'b000011, 6'b000111, 6'b001001:
          exec_to_mem = 1'b1;
        default:
          exec_to_mem = 1'b0;
      endcase
    end else begin
      case (opcode)
        6'b001001, 6'b001010, 6'b001011, 6'b001100,
        6'b001101, 6'b001110, 6'b100011, 6'b101011:
          exec_to_mem = 1'b1;
        default:
          exec_to_mem = 1'b0;
      endcase
    end
  end

  // Next-state selection: watchdog halt beats stall hold beats normal sequencing.
  always_comb begin
    next_state = state_q;
    if (wd_trip) begin
      next_state = HALTED;
    end else if (!stall) begin
      case (state_q)
        FETCH:         next_state = (pc == 32'd0) ? HALTED : DECODE;
        DECODE:        next_state = EXECUTE;
        EXECUTE:       next_state = exec_to_mem ? MEMORY_ACCESS : FETCH;
        MEMORY_ACCESS: next_state = (opcode == OP_LW) ? WRITE_BACK : FETCH;
        WRITE_BACK:    next_state = FETCH;
        HALTED:        next_state = HALTED;
        default:       next_state = HALTED;
      endcase
    end
  end

  // An instruction retires when a post-decode stage hands back to FETCH.
  assign retire = (state_q == EXECUTE || state_q == MEMORY_ACCESS || state_q == WRITE_BACK) &&
                  (next_state == FETCH);

  // State, watchdog, sticky error and retired counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FETCH;
      wd_cnt      <= '0;
      stall_error <= 1'b0;
      retired     <= '0;
    end else begin
      state_q <= next_state;
      if (!stall) begin
        wd_cnt <= '0;
      end else if (!wd_trip) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
      if (wd_trip) begin
        stall_error <= 1'b1;
      end
      if (retire) begin
        retired <= retired + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_state_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_cpu_state_sequencer
//  Description : Self-checking bench for mips_cpu_state_sequencer. One main
//                instance (narrow counter for wrap) and one with a short
//                watchdog limit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_cpu_state_sequencer;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;

  logic        clk;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  func_code;
  logic [31:0] pc;
  logic        mem_read;
  logic        mem_write;
  logic        waitrequest;
  logic        alu_busy;

  logic [2:0]  state_m, state_w;
  logic        active_m, active_w;
  logic        mem_enable_m, mem_enable_w;
  logic        stall_m, stall_w;
  logic        stall_error_m, stall_error_w;
  logic [2:0]  retired_m;
  logic [31:0] retired_w;

  typedef struct packed {
    logic [2:0]  st;
    logic [31:0] ret;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   exp_ret = 0;

  mips_cpu_state_sequencer #(.STALL_LIMIT(1024), .CNT_W(3)) dut_m (
    .clk(clk), .reset(reset), .opcode(opcode), .func_code(func_code), .pc(pc),
    .mem_read(mem_read), .mem_write(mem_write), .waitrequest(waitrequest),
    .alu_busy(alu_busy), .state(state_m), .active(active_m),
    .mem_enable(mem_enable_m), .stall(stall_m), .stall_error(stall_error_m),
    .retired(retired_m)
  );

  mips_cpu_state_sequencer #(.STALL_LIMIT(4), .CNT_W(32)) dut_w (
    .clk(clk), .reset(reset), .opcode(opcode), .func_code(func_code), .pc(pc),
    .mem_read(mem_read), .mem_write(mem_write), .waitrequest(waitrequest),
    .alu_busy(alu_busy), .state(state_w), .active(active_w),
    .mem_enable(mem_enable_w), .stall(stall_w), .stall_error(stall_error_w),
    .retired(retired_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1; pc = 32'hBFC0_0000; opcode = OP_ADDIU; func_code = 6'd0;
    mem_read = 1'b1; mem_write = 1'b0; waitrequest = 1'b0; alu_busy = 1'b0;
    #2;
    total++; if (state_m !== 3'b000) begin bad++; $display("FAIL reset_state: got %b want 000", state_m); end
    total++; if (active_m !== 1'b1) begin bad++; $display("FAIL reset_active: got %b want 1", active_m); end
    total++; if (stall_error_m !== 1'b0) begin bad++; $display("FAIL reset_stall_error: got %b want 0", stall_error_m); end
    total++; if (retired_m !== 3'd0) begin bad++; $display("FAIL reset_retired: got %0d want 0", retired_m); end
    @(posedge clk); #1;
    total++; if (state_m !== 3'b000) begin bad++; $display("FAIL reset_hold_state: got %b want 000", state_m); end
    reset = 1'b0;
    exp_ret = 0;
  endtask

  task automatic test_addiu();
    int seq[4];
    exp_t e;
    seq = '{1, 2, 3, 0};
    opcode = OP_ADDIU; pc = 32'hBFC0_0000;
    total++; if (mem_enable_m !== 1'b1) begin bad++; $display("FAIL addiu_mem_enable: got %b want 1", mem_enable_m); end
    for (int i = 0; i < 4; i++) begin
      if (seq[i] == 0) exp_ret++;
      sb.push_back('{st: 3'(seq[i]), ret: 32'(exp_ret)});
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (state_m !== e.st || retired_m !== e.ret[2:0]) begin
        bad++; $display("FAIL addiu[%0d]: got state=%b retired=%0d want state=%b retired=%0d", i, state_m, retired_m, e.st, e.ret[2:0]);
      end
    end
  endtask

  task automatic test_lw();
    int seq[8];
    exp_t e;
    seq = '{1, 2, 3, 3, 3, 3, 4, 0};
    opcode = OP_LW; func_code = 6'd0; mem_read = 1'b1; pc = 32'h0040_0010;
    for (int i = 0; i < 8; i++) begin
      // i==7 raises waitrequest in WRITE_BACK, which must be ignored
      waitrequest = (i >= 3 && i <= 5) || (i == 7);
      #1;
      if (i >= 3 && i <= 5) begin
        total++; if (stall_m !== 1'b1) begin bad++; $display("FAIL lw_stall[%0d]: got %b want 1", i, stall_m); end
      end
      if (i == 7) begin
        total++; if (stall_m !== 1'b0) begin bad++; $display("FAIL lw_wb_ignore[%0d]: got %b want 0", i, stall_m); end
      end
      if (seq[i] == 0) exp_ret++;
      sb.push_back('{st: 3'(seq[i]), ret: 32'(exp_ret)});
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (state_m !== e.st || retired_m !== e.ret[2:0]) begin
        bad++; $display("FAIL lw[%0d]: got state=%b retired=%0d want state=%b retired=%0d", i, state_m, retired_m, e.st, e.ret[2:0]);
      end
    end
    waitrequest = 1'b0;
  endtask

  task automatic test_div_jr();
    int seq[8];
    int seq_jr[3];
    exp_t e;
    seq = '{1, 2, 2, 2, 2, 2, 2, 0};
    seq_jr = '{1, 2, 0};
    opcode = OP_R; func_code = FN_DIV; pc = 32'h0040_0020;
    for (int i = 0; i < 8; i++) begin
      // i==1 is DECODE with alu_busy high, which must be ignored
      alu_busy = (i >= 1 && i <= 6);
      #1;
      total++;
      if (stall_m !== (i >= 2 && i <= 6)) begin
        bad++; $display("FAIL div_stall[%0d]: got %b want %b", i, stall_m, (i >= 2 && i <= 6));
      end
      if (seq[i] == 0) exp_ret++;
      sb.push_back('{st: 3'(seq[i]), ret: 32'(exp_ret)});
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (state_m !== e.st || retired_m !== e.ret[2:0]) begin
        bad++; $display("FAIL div[%0d]: got state=%b retired=%0d want state=%b retired=%0d", i, state_m, retired_m, e.st, e.ret[2:0]);
      end
    end
    alu_busy = 1'b0;
    func_code = FN_JR;
    for (int i = 0; i < 3; i++) begin
      if (seq_jr[i] == 0) exp_ret++;
      sb.push_back('{st: 3'(seq_jr[i]), ret: 32'(exp_ret)});
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (state_m !== e.st || retired_m !== e.ret[2:0]) begin
        bad++; $display("FAIL jr[%0d]: got state=%b retired=%0d want state=%b retired=%0d", i, state_m, retired_m, e.st, e.ret[2:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops[5];
    logic [5:0] fns[5];
    int         lens[5];
    exp_t       e;
    int         sv;
    ops  = '{OP_R,    OP_SW, OP_BEQ, OP_R,    OP_R};
    fns  = '{FN_ADDU, 6'd0,  6'd0,   FN_MFHI, FN_SRA};
    lens = '{4,       4,     3,      3,       4};
    mem_read = 1'b1;
    for (int j = 0; j < 5; j++) begin
      opcode = ops[j]; func_code = fns[j]; pc = 32'h0040_0100 + 32'(j * 4);
      for (int i = 0; i < lens[j]; i++) begin
        // waitrequest during DECODE/EXECUTE must not stall
        waitrequest = (i == 1 || i == 2);
        sv = (i == lens[j] - 1) ? 0 : i + 1;
        if (sv == 0) exp_ret++;
        sb.push_back('{st: 3'(sv), ret: 32'(exp_ret)});
        @(posedge clk); #1;
        e = sb.pop_front();
        total++;
        if (state_m !== e.st || retired_m !== e.ret[2:0]) begin
          bad++; $display("FAIL b2b[%0d][%0d]: got state=%b retired=%0d want state=%b retired=%0d", j, i, state_m, retired_m, e.st, e.ret[2:0]);
        end
      end
    end
    waitrequest = 1'b0;
  endtask

  task automatic test_halt();
    exp_t e;
    pc = 32'd0; mem_read = 1'b1; waitrequest = 1'b1; opcode = OP_ADDIU;
    #1;
    total++; if (mem_enable_m !== 1'b0) begin bad++; $display("FAIL halt_mem_enable: got %b want 0", mem_enable_m); end
    total++; if (stall_m !== 1'b0) begin bad++; $display("FAIL halt_stall: got %b want 0", stall_m); end
    for (int i = 0; i < 101; i++) begin
      sb.push_back('{st: 3'b101, ret: 32'(exp_ret)});
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (state_m !== e.st || retired_m !== e.ret[2:0]) begin
        bad++; $display("FAIL halt[%0d]: got state=%b retired=%0d want state=%b retired=%0d", i, state_m, retired_m, e.st, e.ret[2:0]);
      end
    end
    total++; if (active_m !== 1'b0) begin bad++; $display("FAIL halt_active: got %b want 0", active_m); end
    total++; if (stall_error_m !== 1'b0) begin bad++; $display("FAIL halt_stall_error: got %b want 0", stall_error_m); end
    waitrequest = 1'b0;
  endtask

  task automatic test_watchdog();
    exp_t e;
    reset = 1'b1; #1; reset = 1'b0;
    exp_ret = 0;
    pc = 32'hBFC0_0000; mem_read = 1'b1; waitrequest = 1'b1;
    #1;
    total++; if (stall_w !== 1'b1) begin bad++; $display("FAIL wd_stall: got %b want 1", stall_w); end
    for (int i = 0; i < 5; i++) begin
      sb.push_back('{st: (i == 4) ? 3'b101 : 3'b000, ret: 32'd0});
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (state_w !== e.st || retired_w !== e.ret) begin
        bad++; $display("FAIL wd[%0d]: got state=%b retired=%0d want state=%b retired=%0d", i, state_w, retired_w, e.st, e.ret);
      end
      total++;
      if (stall_error_w !== (i == 4)) begin
        bad++; $display("FAIL wd_error[%0d]: got %b want %b", i, stall_error_w, (i == 4));
      end
    end
    total++; if (active_w !== 1'b0) begin bad++; $display("FAIL wd_active: got %b want 0", active_w); end
    total++; if (stall_w !== 1'b0) begin bad++; $display("FAIL wd_stall_after: got %b want 0", stall_w); end
    total++; if (state_m !== 3'b000 || stall_error_m !== 1'b0) begin
      bad++; $display("FAIL wd_long_limit: got state=%b err=%b want state=000 err=0", state_m, stall_error_m);
    end
    @(posedge clk); #1;
    total++; if (stall_error_w !== 1'b1) begin bad++; $display("FAIL wd_sticky: got %b want 1", stall_error_w); end
    waitrequest = 1'b0;
  endtask

  task automatic test_wrap_async_reset();
    exp_t e;
    int   sv;
    reset = 1'b1; #1; reset = 1'b0;
    exp_ret = 0;
    opcode = OP_R; func_code = FN_JR; pc = 32'h0040_0200; mem_read = 1'b1;
    for (int k = 0; k < 11; k++) begin
      for (int i = 0; i < 3; i++) begin
        sv = (i == 2) ? 0 : i + 1;
        if (sv == 0) exp_ret++;
        sb.push_back('{st: 3'(sv), ret: 32'(exp_ret)});
        @(posedge clk); #1;
        e = sb.pop_front();
        total++;
        if (state_m !== e.st || retired_m !== e.ret[2:0]) begin
          bad++; $display("FAIL wrap[%0d][%0d]: got state=%b retired=%0d want state=%b retired=%0d", k, i, state_m, retired_m, e.st, e.ret[2:0]);
        end
      end
      if (k == 7) begin
        total++; if (retired_m !== 3'd0) begin bad++; $display("FAIL wrap_to_zero: got %0d want 0", retired_m); end
      end
    end
    opcode = OP_ADDIU;
    repeat (3) @(posedge clk);
    #1;
    total++; if (state_m !== 3'b011) begin bad++; $display("FAIL async_pre_state: got %b want 011", state_m); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (state_m !== 3'b000) begin bad++; $display("FAIL async_state: got %b want 000", state_m); end
    total++; if (retired_m !== 3'd0) begin bad++; $display("FAIL async_retired: got %0d want 0", retired_m); end
    total++; if (stall_error_w !== 1'b0 || state_w !== 3'b000) begin
      bad++; $display("FAIL async_wd_clear: got err=%b state=%b want err=0 state=000", stall_error_w, state_w);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_addiu();
    test_lw();
    test_div_jr();
    test_back_to_back();
    test_halt();
    test_watchdog();
    test_wrap_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got no finish want finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
